transmissor_resultado: RTL and testbench
========================================

// Module: transmissor_resultado
// PURPOSE
//  FPGA->HPS return path of the coprocessor's HPS word interface. Holds the 5x5 result
//  matrix (25 x 8-bit) written by the arithmetic core and streams it to the HPS, one
//  element per 4-phase handshake, in index order 0..24. Partner of the input-side
//  manager that fills matrizA/matrizB. Its 32-bit word is OR-merged with that manager's.
// PARAMETERS
//  N_ELEM   25  elements per result matrix
//  DATA_W   8   bits per element
//  IDX_W    5   index width, ceil(log2(N_ELEM))
// PORTS
//  clk       in   1       system clock; single clock domain
//  reset     in   1       synchronous, active-high reset
//  res_we    in   1       result-element write strobe from arithmetic core
//  res_addr  in   IDX_W   element index for write; addr >= N_ELEM ignored
//  res_data  in   DATA_W  element value
//  start     in   1       1-cycle pulse: result matrix complete, begin transfer
//  busy      out  1       transfer in progress (states SEND, WAIT_LOW)
//  entrada   in   32      HPS->FPGA word; [30]=ack_HPS, [29]=abort; all other bits ignored
//  saida     out  32      FPGA->HPS word; [31]=0 always (owned by input manager),
//                         [30]=valid, [29]=done, [28]=busy, [20:16]=index, [7:0]=data, rest 0
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE, saida=0, busy=0, index=0. Buffer contents NOT cleared.
//    Reset mid-transfer aborts immediately; next edge outputs all 0.
//  - Writes: accepted only in IDLE/DONE; ignored in SEND/WAIT_LOW. Write and start in the
//    same cycle: write committed, new value forwarded if it targets element 0.
//  - States: IDLE, SEND, WAIT_LOW, DONE. All outputs registered.
//  - IDLE/DONE + start=1 -> SEND next edge: index=0, data=buf[0], valid=1, done=0, busy=1.
//    Latency start->valid: 1 cycle. start ignored in SEND/WAIT_LOW.
//  - SEND: data/index held stable while valid=1. ack_HPS sampled 1 -> WAIT_LOW, valid=0.
//  - WAIT_LOW: ack_HPS sampled 0 ->
//      index<N_ELEM-1: index+1, data=buf[index+1], valid=1, -> SEND (same edge);
//      index==N_ELEM-1: -> DONE, done=1, busy=0, valid=0, index holds 24.
//  - DONE: done held until next start (restart) or abort. No wrap to element 0 without start.
//  - ack_HPS=1 in IDLE/DONE: ignored. ack_HPS already high on SEND entry: handled as a
//    normal ack (no stale-ack filtering; HPS must drop ack before the next element).
//  - abort=1 in any state -> IDLE next edge, valid=0, done=0, busy=0, index=0; abort has
//    priority over start and ack in the same cycle.
//  - Min. cycles per element: 2 (SEND+WAIT_LOW) plus HPS latency.
// STRUCTURE
//  - Shared package coproc_pkg: N_ELEM, DATA_W, IDX_W, saida/entrada bit positions
//    (valid/done/busy/ack/abort/index/data fields), state encoding typedef.
//  - Sub-module buffer_resultado: 25x8 register file, 1 write port, 1 comb read port.
//  - Top: FSM + output register; read address = next index.
// TESTING
//  1 Write buf[i]=i+1 (i=0..24), start, HPS model acks each -> 25 words data 1..25,
//    index 0..24 in order, then done=1, busy=0, valid=0.
//  2 Reset pulsed while in WAIT_LOW at index 7 -> next edge saida=0; new start restarts at 0.
//  3 res_we addr=3 data=0xAA during SEND -> ignored; element 3 keeps old value 0x04.
//  4 res_we addr=0 data=0x5A in same cycle as start -> first word data=0x5A, index=0.
//  5 abort=1 together with ack at index 10 -> IDLE, all fields 0; ack ignored.
//  6 start in DONE -> second full transfer; start pulses during SEND ignored; res_addr=27 write ignored.

Source files
------------

// File: rtl/coproc_pkg.sv
// Shared definitions for the coprocessor's HPS word interface.
// Holds the result-matrix geometry, the bit positions of the saida/entrada
// words, and the state encoding of the result transmitter FSM.
package coproc_pkg;

  localparam int N_ELEM = 25;  // elements per 5x5 result matrix
  localparam int DATA_W = 8;   // bits per element
  localparam int IDX_W  = 5;   // ceil(log2(N_ELEM))

  // Index of the final element, sized to the index field.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  // FPGA->HPS word (saida). Bit 31 belongs to the input-side manager.
  localparam int SAIDA_VALID_BIT = 30;
  localparam int SAIDA_DONE_BIT  = 29;
  localparam int SAIDA_BUSY_BIT  = 28;
  localparam int SAIDA_IDX_LSB   = 16;
  localparam int SAIDA_DATA_LSB  = 0;

  // HPS->FPGA word (entrada).
  localparam int ENTRADA_ACK_BIT   = 30;
  localparam int ENTRADA_ABORT_BIT = 29;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_LOW = 2'd2,
    ST_DONE     = 2'd3
  } tx_state_e;

endpackage

// File: rtl/buffer_resultado.sv
// Result matrix storage: N_ELEM x DATA_W register file.
// Ports:
//   clk      - system clock
//   we       - write strobe (already qualified by the caller's FSM state)
//   wr_addr  - write index; indices >= N_ELEM are dropped
//   wr_data  - write value
//   rd_addr  - combinational read index; indices >= N_ELEM read as 0
//   rd_data  - combinational read value
// Contents are intentionally not reset.
module buffer_resultado
  import coproc_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [N_ELEM];

  // Single write port; out-of-range indices must not alias onto real entries.
  always_ff @(posedge clk) begin
    if (we && (wr_addr <= LAST_IDX)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Combinational read port with out-of-range guard.
  always_comb begin
    rd_data = {DATA_W{1'b0}};
    if (rd_addr <= LAST_IDX) begin
      rd_data = mem_q[rd_addr];
    end else begin
      rd_data = {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/transmissor_resultado.sv
// FPGA->HPS return path: streams the 5x5 result matrix to the HPS, one element
// per 4-phase handshake (valid up, ack up, valid down, ack down), index 0..24.
// Ports:
//   clk, reset   - single clock, synchronous active-high reset
//   res_we/addr/data - result element writes from the arithmetic core
//   start        - 1-cycle pulse, result matrix complete
//   busy         - transfer in progress
//   entrada      - HPS->FPGA word: [30]=ack_HPS, [29]=abort
//   saida        - FPGA->HPS word: [30]=valid [29]=done [28]=busy
//                  [20:16]=index [7:0]=data, all other bits 0
module transmissor_resultado
  import coproc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              res_we,
  input  logic [IDX_W-1:0]  res_addr,
  input  logic [DATA_W-1:0] res_data,
  input  logic              start,
  output logic              busy,
  input  logic [31:0]       entrada,
  output logic [31:0]       saida
);

  tx_state_e         state_q, state_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              ack_s;
  logic              abort_s;
  logic              wr_allow_s;
  logic              buf_we_s;
  logic [IDX_W-1:0]  rd_addr_s;
  logic [DATA_W-1:0] rd_data_s;
  logic [DATA_W-1:0] first_data_s;
  logic              unused_entrada_s;

  assign ack_s            = entrada[ENTRADA_ACK_BIT];
  assign abort_s          = entrada[ENTRADA_ABORT_BIT];
  assign unused_entrada_s = ^{entrada[31], entrada[28:0]};

  // The buffer may only change while nothing is being streamed out.
  assign wr_allow_s = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign buf_we_s   = res_we && wr_allow_s;

  // Read address is the index that will be presented on the next edge.
  always_comb begin
    rd_addr_s = {IDX_W{1'b0}};
    case (state_q)
      ST_WAIT_LOW: rd_addr_s = index_q + {{(IDX_W-1){1'b0}}, 1'b1};
      default:     rd_addr_s = {IDX_W{1'b0}};
    endcase
  end

  // A write to element 0 in the same cycle as start must reach the first word.
  always_comb begin
    first_data_s = rd_data_s;
    if (buf_we_s && (res_addr == {IDX_W{1'b0}})) begin
      first_data_s = res_data;
    end else begin
      first_data_s = rd_data_s;
    end
  end

  buffer_resultado u_buffer (
    .clk     (clk),
    .we      (buf_we_s),
    .wr_addr (res_addr),
    .wr_data (res_data),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      index_q <= {IDX_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; abort overrides everything.
  always_comb begin
    state_d = state_q;
    if (abort_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) state_d = ST_SEND;
          else       state_d = state_q;
        end
        ST_SEND: begin
          if (ack_s) state_d = ST_WAIT_LOW;
          else       state_d = ST_SEND;
        end
        ST_WAIT_LOW: begin
          if (ack_s)                    state_d = ST_WAIT_LOW;
          else if (index_q == LAST_IDX) state_d = ST_DONE;
          else                          state_d = ST_SEND;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output-register next values; everything holds unless a transition changes it.
  always_comb begin
    index_d = index_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = done_q;
    busy_d  = busy_q;
    if (abort_s) begin
      index_d = {IDX_W{1'b0}};
      data_d  = {DATA_W{1'b0}};
      valid_d = 1'b0;
      done_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            index_d = {IDX_W{1'b0}};
            data_d  = first_data_s;
            valid_d = 1'b1;
            done_d  = 1'b0;
            busy_d  = 1'b1;
          end else begin
            index_d = index_q;
          end
        end
        ST_SEND: begin
          if (ack_s) valid_d = 1'b0;
          else       valid_d = valid_q;
        end
        ST_WAIT_LOW: begin
          if (ack_s) begin
            valid_d = 1'b0;
          end else if (index_q == LAST_IDX) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            valid_d = 1'b0;
          end else begin
            index_d = rd_addr_s;
            data_d  = rd_data_s;
            valid_d = 1'b1;
          end
        end
        default: begin
          index_d = {IDX_W{1'b0}};
          data_d  = {DATA_W{1'b0}};
          valid_d = 1'b0;
          done_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // Assemble the HPS word from registered fields only.
  always_comb begin
    saida = 32'd0;
    saida[SAIDA_VALID_BIT] = valid_q;
    saida[SAIDA_DONE_BIT]  = done_q;
    saida[SAIDA_BUSY_BIT]  = busy_q;
    saida[SAIDA_IDX_LSB +: IDX_W]   = index_q;
    saida[SAIDA_DATA_LSB +: DATA_W] = data_q;
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_transmissor_resultado.sv
// Directed self-checking bench for transmissor_resultado.
module tb_transmissor_resultado;

  logic        clk;
  logic        reset;
  logic        res_we;
  logic [4:0]  res_addr;
  logic [7:0]  res_data;
  logic        start;
  logic        busy;
  logic [31:0] entrada;
  logic [31:0] saida;

  logic        ack;
  logic        abort;
  logic [7:0]  exp_mem [25];
  int          n_pass;
  int          n_total;

  assign entrada = {1'b0, ack, abort, 29'd0};

  transmissor_resultado dut (
    .clk      (clk),
    .reset    (reset),
    .res_we   (res_we),
    .res_addr (res_addr),
    .res_data (res_data),
    .start    (start),
    .busy     (busy),
    .entrada  (entrada),
    .saida    (saida)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(logic v, logic d, logic b, logic [4:0] i, logic [7:0] dt);
    return {1'b0, v, d, b, 7'd0, i, 8'd0, dt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One full handshake for the element currently presented at index k.
  task automatic do_elem(int k);
    chk($sformatf("elem%0d_valid", k), saida, word(1'b1, 1'b0, 1'b1, 5'(k), exp_mem[k]));
    ack = 1'b1;
    tick();
    chk($sformatf("elem%0d_acked", k), saida, word(1'b0, 1'b0, 1'b1, 5'(k), exp_mem[k]));
    ack = 1'b0;
    tick();
  endtask

  task automatic chk_done(string tag);
    chk({tag, "_flags"}, {28'd0, saida[31:28]}, 32'h2);
    chk({tag, "_index"}, {27'd0, saida[20:16]}, 32'd24);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b1; res_we = 1'b0; res_addr = 5'd0; res_data = 8'd0;
    start = 1'b0; ack = 1'b0; abort = 1'b0;
    tick(); tick();
    chk("reset_saida", saida, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_saida", saida, 32'd0);

    // Fill buffer with i+1.
    for (int i = 0; i < 25; i++) begin
      res_we = 1'b1; res_addr = 5'(i); res_data = 8'(i + 1);
      exp_mem[i] = 8'(i + 1);
      tick();
    end
    res_we = 1'b0;
    chk("idle_after_writes", saida, 32'd0);

    // Test 1: full transfer, latency start->valid is one edge.
    pulse_start();
    chk("t1_busy_port", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 25; k++) do_elem(k);
    chk_done("t1_done");
    // ack in DONE is ignored and done holds.
    ack = 1'b1; tick(); tick(); ack = 1'b0; tick();
    chk_done("t1_done_hold");

    // Test 6: out-of-range write ignored, restart from DONE.
    res_we = 1'b1; res_addr = 5'd27; res_data = 8'hFF; tick(); res_we = 1'b0;
    pulse_start();
    do_elem(0);
    // Test 3 + start-during-SEND: write to element 3 and start pulse ignored.
    res_we = 1'b1; res_addr = 5'd3; res_data = 8'hAA; start = 1'b1;
    tick();
    res_we = 1'b0; start = 1'b0;
    chk("t3_send_stable", saida, word(1'b1, 1'b0, 1'b1, 5'd1, 8'd2));
    for (int k = 1; k < 25; k++) do_elem(k);
    chk_done("t6_done");

    // Test 4: write element 0 in the same cycle as start.
    res_we = 1'b1; res_addr = 5'd0; res_data = 8'h5A; start = 1'b1;
    exp_mem[0] = 8'h5A;
    tick();
    res_we = 1'b0; start = 1'b0;
    chk("t4_fwd_word", saida, word(1'b1, 1'b0, 1'b1, 5'd0, 8'h5A));
    for (int k = 0; k < 7; k++) do_elem(k);

    // Test 2: reset while in WAIT_LOW at index 7.
    chk("t2_idx7", saida, word(1'b1, 1'b0, 1'b1, 5'd7, 8'd8));
    ack = 1'b1; tick();
    chk("t2_waitlow", saida, word(1'b0, 1'b0, 1'b1, 5'd7, 8'd8));
    reset = 1'b1; ack = 1'b0; tick();
    chk("t2_reset_saida", saida, 32'd0);
    chk("t2_reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0; tick();
    chk("t2_idle", saida, 32'd0);
    pulse_start();
    for (int k = 0; k < 10; k++) do_elem(k);

    // Test 5: abort together with ack at index 10.
    chk("t5_idx10", saida, word(1'b1, 1'b0, 1'b1, 5'd10, 8'd11));
    abort = 1'b1; ack = 1'b1; tick();
    chk("t5_abort_saida", saida, 32'd0);
    chk("t5_abort_busy", {31'd0, busy}, 32'd0);
    abort = 1'b0; tick();
    chk("t5_ack_ignored", saida, 32'd0);
    ack = 1'b0;
    // abort beats start.
    abort = 1'b1; start = 1'b1; tick();
    abort = 1'b0; start = 1'b0;
    chk("t5_abort_vs_start", saida, 32'd0);
    tick();
    chk("t5_still_idle", saida, 32'd0);
    // Restart from IDLE, run to completion.
    pulse_start();
    for (int k = 0; k < 25; k++) do_elem(k);
    chk_done("t5_final_done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
